// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
//   fetch_state_e : fetch FSM states (boot, running, holding a buffered response)
//   NOP_INSTR     : instruction presented on if_instr out of reset (addi x0,x0,0)
//   PC_STEP       : byte increment between sequential fetches
//   align_pc()    : forces a byte address onto a word boundary
package fetch_pkg;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry hold buffer for a memory response that arrives while decode is
// stalled.
//   clk, rst       : clock, synchronous active-low reset
//   i_load         : capture (i_load_pc, i_load_instr) and mark valid
//   i_drain        : entry consumed; clear valid
//   i_flush        : discard entry (redirect); wins over load and drain
//   o_valid        : entry holds a response not yet passed to decode
//   o_pc, o_instr  : buffered PC and instruction word
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_drain,
  input  logic        i_flush,
  input  logic [31:0] i_load_pc,
  input  logic [31:0] i_load_instr,
  output logic        o_valid,
  output logic [31:0] o_pc,
  output logic [31:0] o_instr
);

  logic        r_valid;
  logic [31:0] r_pc;
  logic [31:0] r_instr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_pc    <= 32'd0;
      r_instr <= NOP_INSTR;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_load_pc;
      r_instr <= i_load_instr;
    end else if (i_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_instr = r_instr;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one word read per cycle to instruction memory
// (single-cycle response latency), registers the response for decode, holds
// its output under decode stall, and restarts at a redirect target.
//
// Handshake: a decode-stage instruction is transferred when if_valid=1 and
// stall=0 in the same cycle; while stall=1 the if_* outputs are held and no new
// request is issued, so at most one response (parked in the hold buffer) can
// be outstanding across a stall.
//
//   clk, rst                 : clock, synchronous active-low reset
//   stall                    : decode cannot accept this cycle
//   redirect_valid/pc        : restart fetch at redirect_pc (word aligned)
//   imem_request/we_re/mask  : memory request (always a full-word read)
//   imem_address             : word address = pc_q[9:2] (wraps at 256 words)
//   imem_valid/data          : memory response, one cycle after the request
//   if_valid/pc/instr        : registered instruction to decode
//   dbg_state                : current FSM state (fetch_state_e encoding)
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_request,
  output logic        imem_we_re,
  output logic [3:0]  imem_mask,
  output logic [7:0]  imem_address,
  input  logic        imem_valid,
  input  logic [31:0] imem_data,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic [1:0]  dbg_state
);

  fetch_state_e r_state;
  logic [31:0]  r_pc_q;
  logic [31:0]  r_inflight_pc;
  logic         r_if_valid;
  logic [31:0]  r_if_pc;
  logic [31:0]  r_if_instr;

  logic         w_active;
  logic         w_redirect;
  logic         w_issue;
  logic         w_hb_load;
  logic         w_hb_drain;
  logic         w_hb_valid;
  logic [31:0]  w_hb_pc;
  logic [31:0]  w_hb_instr;

  // Redirect is ignored in S_BOOT; otherwise it overrides stall.
  assign w_active   = rst && (r_state != S_BOOT);
  assign w_redirect = w_active && redirect_valid;
  assign w_issue    = w_active && !redirect_valid && !stall;

  // A response landing during a stall is parked; it is released on the first
  // unstalled cycle in S_HOLD.
  assign w_hb_load  = w_active && !redirect_valid && stall &&
                      (r_state == S_RUN) && imem_valid;
  assign w_hb_drain = w_active && !redirect_valid && !stall &&
                      (r_state == S_HOLD);

  fetch_skid_buf u_hold_buf (
    .clk          (clk),
    .rst          (rst),
    .i_load       (w_hb_load),
    .i_drain      (w_hb_drain),
    .i_flush      (w_redirect),
    .i_load_pc    (r_inflight_pc),
    .i_load_instr (imem_data),
    .o_valid      (w_hb_valid),
    .o_pc         (w_hb_pc),
    .o_instr      (w_hb_instr)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= S_BOOT;
      r_pc_q        <= RESET_PC;
      r_inflight_pc <= 32'd0;
      r_if_valid    <= 1'b0;
      r_if_pc       <= 32'd0;
      r_if_instr    <= NOP_INSTR;
    end else if (r_state == S_BOOT) begin
      // Any response arriving here belongs to a pre-reset request.
      r_state <= S_RUN;
    end else if (redirect_valid) begin
      r_if_valid <= 1'b0;
      r_pc_q     <= align_pc(redirect_pc);
      r_state    <= S_RUN;
    end else if (stall) begin
      if ((r_state == S_RUN) && imem_valid) begin
        r_state <= S_HOLD;
      end
    end else begin
      r_inflight_pc <= r_pc_q;
      r_pc_q        <= r_pc_q + PC_STEP;
      if ((r_state == S_HOLD) && w_hb_valid) begin
        r_if_valid <= 1'b1;
        r_if_pc    <= w_hb_pc;
        r_if_instr <= w_hb_instr;
        r_state    <= S_RUN;
      end else if (r_state == S_HOLD) begin
        r_if_valid <= 1'b0;
        r_state    <= S_RUN;
      end else if (imem_valid) begin
        r_if_valid <= 1'b1;
        r_if_pc    <= r_inflight_pc;
        r_if_instr <= imem_data;
      end else begin
        r_if_valid <= 1'b0;
      end
    end
  end

  assign imem_request = w_issue;
  assign imem_we_re   = 1'b0;
  assign imem_mask    = 4'b1111;
  assign imem_address = r_pc_q[9:2];

  assign if_valid  = r_if_valid;
  assign if_pc     = r_if_pc;
  assign if_instr  = r_if_instr;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a one-cycle-latency instruction memory returning
// 32'h1000_0000 + word_address, and an in-order scoreboard of expected
// (pc, instr) pairs consumed whenever decode accepts (if_valid && !stall).
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_request;
  logic        imem_we_re;
  logic [3:0]  imem_mask;
  logic [7:0]  imem_address;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_data  = 32'd0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [1:0]  dbg_state;
  logic        inj_stale;

  logic [63:0] exp_q[$];
  int          vectors;
  int          miscompares;
  int          consumed;

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_request   (imem_request),
    .imem_we_re     (imem_we_re),
    .imem_mask      (imem_mask),
    .imem_address   (imem_address),
    .imem_valid     (imem_valid),
    .imem_data      (imem_data),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  always @(posedge clk) begin
    imem_valid <= imem_request | inj_stale;
    imem_data  <= inj_stale ? 32'hDEAD_BEEF : (32'h1000_0000 + {24'd0, imem_address});
  end

  // ---------------- driver / scoreboard tasks ----------------
  task automatic push_exp(input logic [31:0] pc);
    logic [31:0] ins;
    ins = 32'h1000_0000 + {24'd0, pc[9:2]};
    exp_q.push_back({pc, ins});
  endtask

  // One clock cycle: inputs are stable across it; the accepted output is
  // scored at the falling edge, then control returns just after the next
  // rising edge.
  task automatic cycle();
    logic [63:0] e;
    @(negedge clk);
    if (if_valid === 1'b1 && stall === 1'b0 && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      consumed++;
      vectors++;
      if ({if_pc, if_instr} !== e) begin
        miscompares++;
        $display("FAIL sb_out: got pc=%h instr=%h expected pc=%h instr=%h",
                 if_pc, if_instr, e[63:32], e[31:0]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0; inj_stale = 1'b0;
    cycle();
    cycle();
    vectors++;
    if (if_valid !== 1'b0 || if_pc !== 32'd0 || if_instr !== NOP) begin
      miscompares++;
      $display("FAIL reset_out: got v=%b pc=%h instr=%h expected v=0 pc=0 instr=%h", if_valid, if_pc, if_instr, NOP);
    end
    vectors++;
    if (imem_request !== 1'b0 || imem_we_re !== 1'b0 || imem_mask !== 4'hF) begin
      miscompares++;
      $display("FAIL reset_mem: got req=%b we=%b mask=%h expected 0 0 f", imem_request, imem_we_re, imem_mask);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (imem_request !== 1'b0 || dbg_state !== 2'd0) begin
      miscompares++;
      $display("FAIL boot_req: got req=%b state=%0d expected req=0 state=0", imem_request, dbg_state);
    end
    cycle();
    vectors++;
    if (imem_request !== 1'b1 || imem_address !== 8'h00 || dbg_state !== 2'd1) begin
      miscompares++;
      $display("FAIL first_req: got req=%b addr=%h state=%0d expected 1 00 1", imem_request, imem_address, dbg_state);
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 8; i++) push_exp(32'(i * 4));
    repeat (10) cycle();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL stream_count: got %0d left expected 0", exp_q.size());
    end
  endtask

  task automatic test_stall_inflight();
    redirect_valid = 1'b1; redirect_pc = 32'd0;
    cycle();
    redirect_valid = 1'b0;
    vectors++;
    if (if_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_redir: got if_valid=%b expected 0", if_valid);
    end
    for (int i = 0; i < 4; i++) push_exp(32'(i * 4));
    repeat (3) cycle();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      vectors++;
      if (imem_request !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_req: cycle %0d got req=%b expected 0", k, imem_request);
      end
      vectors++;
      if (if_valid !== 1'b1 || if_pc !== 32'h4) begin
        miscompares++;
        $display("FAIL stall_hold: cycle %0d got v=%b pc=%h expected v=1 pc=00000004", k, if_valid, if_pc);
      end
      cycle();
    end
    vectors++;
    if (dbg_state !== 2'd2) begin
      miscompares++;
      $display("FAIL stall_state: got %0d expected 2", dbg_state);
    end
    stall = 1'b0;
    repeat (3) cycle();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL stall_count: got %0d left expected 0", exp_q.size());
    end
  endtask

  task automatic test_redirect_over_stall();
    stall = 1'b1;
    cycle();
    vectors++;
    if (dbg_state !== 2'd2) begin
      miscompares++;
      $display("FAIL ros_hold: got state=%0d expected 2", dbg_state);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    #1;
    vectors++;
    if (imem_request !== 1'b0) begin
      miscompares++;
      $display("FAIL ros_req: got %b expected 0", imem_request);
    end
    cycle();
    redirect_valid = 1'b0; stall = 1'b0;
    push_exp(32'h40);
    push_exp(32'h44);
    #1;
    vectors++;
    if (if_valid !== 1'b0 || imem_request !== 1'b1 || imem_address !== 8'h10) begin
      miscompares++;
      $display("FAIL ros_n1: got v=%b req=%b addr=%h expected 0 1 10", if_valid, imem_request, imem_address);
    end
    cycle();
    vectors++;
    if (if_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL ros_n2: got if_valid=%b expected 0", if_valid);
    end
    cycle();
    vectors++;
    if (if_valid !== 1'b1 || if_pc !== 32'h40) begin
      miscompares++;
      $display("FAIL ros_n3: got v=%b pc=%h expected 1 00000040", if_valid, if_pc);
    end
    cycle();
    cycle();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL ros_count: got %0d left expected 0", exp_q.size());
    end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 32'h3FE;
    cycle();
    redirect_valid = 1'b0;
    push_exp(32'h3FC);
    push_exp(32'h400);
    #1;
    vectors++;
    if (imem_address !== 8'hFF || imem_request !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_ff: got addr=%h req=%b expected ff 1", imem_address, imem_request);
    end
    cycle();
    vectors++;
    if (imem_address !== 8'h00) begin
      miscompares++;
      $display("FAIL wrap_00: got addr=%h expected 00", imem_address);
    end
    repeat (3) cycle();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL wrap_count: got %0d left expected 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back_random();
    int start;
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    cycle();
    redirect_valid = 1'b0;
    for (int i = 0; i < 64; i++) push_exp(32'h100 + 32'(i * 4));
    start = consumed;
    for (int k = 0; k < 40; k++) begin
      stall = ($urandom_range(0, 3) == 0);
      cycle();
    end
    stall = 1'b0;
    repeat (3) cycle();
    vectors++;
    if ((consumed - start) < 10 || exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL rand_progress: got %0d accepted, %0d left expected >=10 accepted and some left",
               consumed - start, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    rst = 1'b0; inj_stale = 1'b1;
    #1;
    vectors++;
    if (imem_request !== 1'b0) begin
      miscompares++;
      $display("FAIL rmid_req: got %b expected 0", imem_request);
    end
    cycle();
    rst = 1'b1; inj_stale = 1'b0;
    vectors++;
    if (if_valid !== 1'b0 || if_instr !== NOP || if_pc !== 32'd0 || dbg_state !== 2'd0) begin
      miscompares++;
      $display("FAIL rmid_out: got v=%b pc=%h instr=%h st=%0d expected 0 0 %h 0", if_valid, if_pc, if_instr, dbg_state, NOP);
    end
    push_exp(32'h0);
    push_exp(32'h4);
    #1;
    vectors++;
    if (imem_request !== 1'b0) begin
      miscompares++;
      $display("FAIL rmid_boot: got req=%b expected 0", imem_request);
    end
    cycle();
    vectors++;
    if (if_valid !== 1'b0 || imem_request !== 1'b1 || imem_address !== 8'h00) begin
      miscompares++;
      $display("FAIL rmid_restart: got v=%b req=%b addr=%h expected 0 1 00", if_valid, imem_request, imem_address);
    end
    cycle();
    vectors++;
    if (if_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rmid_gap: got if_valid=%b expected 0", if_valid);
    end
    cycle();
    vectors++;
    if (if_valid !== 1'b1 || if_pc !== 32'h0) begin
      miscompares++;
      $display("FAIL rmid_first: got v=%b pc=%h expected 1 00000000", if_valid, if_pc);
    end
    cycle();
    cycle();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL rmid_count: got %0d left expected 0", exp_q.size());
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    vectors = 0;
    miscompares = 0;
    consumed = 0;
    test_reset();
    test_stream();
    test_stall_inflight();
    test_redirect_over_stall();
    test_wrap();
    test_back_to_back_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the byte address of the first fetch after reset.
REQ-002 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  meaning the reset: synchronous, active-low (rst=0 sampled at posedge resets).
REQ-004 SHALL have port stall  input  1  meaning decode cannot accept; the if_* outputs must hold.
REQ-005 SHALL have port redirect_valid  input  1  meaning a branch/jump redirect this cycle.
REQ-006 SHALL have port redirect_pc  input  32  meaning the redirect target byte address.
REQ-007 SHALL have port imem_request  output  1  meaning the fetch request to instruction memory.
REQ-008 SHALL have port imem_we_re  output  1  meaning the memory write enable; constant 0 (read).
REQ-009 SHALL have port imem_mask  output  4  meaning the byte mask; constant 4'b1111.
REQ-010 SHALL have port imem_address  output  8  meaning the word address, equal to pc_q[9:2].
REQ-011 SHALL have port imem_valid  input  1  meaning response valid, one cycle after imem_request.
REQ-012 SHALL have port imem_data  input  32  meaning the instruction word, qualified by imem_valid.
REQ-013 SHALL have port if_valid  output  1  meaning the decode-stage instruction is valid.
REQ-014 SHALL have port if_pc  output  32  meaning the byte PC of if_instr.
REQ-015 SHALL have port if_instr  output  32  meaning the fetched instruction.

Function
REQ-016 SHALL implement an FSM with states S_BOOT, S_RUN and S_HOLD.
REQ-017 SHALL, in S_BOOT, drive imem_request=0 and go to S_RUN next cycle.
REQ-018 SHALL keep registers pc_q (next fetch address), inflight_pc (PC of the outstanding request), a 1-entry hold buffer (hb_pc, hb_instr), and output registers if_valid/if_pc/if_instr.
REQ-019 SHALL, in S_RUN with stall=0 and redirect_valid=0, assert imem_request, set inflight_pc<=pc_q, and set pc_q<=pc_q+4 (mod 2^32).
REQ-020 SHALL, in S_RUN with stall=0, register outputs on each cycle: if imem_valid=1, if_valid<=1, if_pc<=inflight_pc and if_instr<=imem_data; otherwise if_valid<=0.
REQ-021 SHALL, in S_RUN with stall=1, drive imem_request=0 and hold pc_q and the if_* outputs; if imem_valid=1 it SHALL capture hb<=(inflight_pc, imem_data) and go to S_HOLD, otherwise stay in S_RUN.
REQ-022 SHALL, in S_HOLD, drive imem_request=0 while stall=1 and hold all state.
REQ-023 SHALL, in S_HOLD with stall=0, load if_valid<=1, if_pc<=hb_pc and if_instr<=hb_instr, issue a request at pc_q (as in REQ-019), and go to S_RUN.
REQ-024 SHALL give redirect_valid=1 priority over stall in any state other than S_BOOT: imem_request=0, any imem_valid response that cycle is discarded, the hold buffer is invalidated, if_valid<=0, pc_q<={redirect_pc[31:2],2'b00}, and next state is S_RUN.
REQ-025 SHALL produce this redirect latency: redirect in cycle N, request at target in N+1, imem_valid in N+2, if_valid=1 with the target PC visible in N+3 (assuming stall=0).
REQ-026 SHALL wrap the word address modulo 256 (pc_q[9:2]) while if_pc carries the full 32-bit PC.
REQ-027 SHALL never have more than one request outstanding, and SHALL never drop or duplicate a response except by redirect.

Reset
REQ-028 SHALL, while rst=0 at a posedge, set state<=S_BOOT, pc_q<=RESET_PC, inflight_pc<=0, hold buffer invalid, if_valid<=0, if_pc<=0 and if_instr<=32'h0000_0013 (NOP).
REQ-029 SHALL, on reset mid-operation, discard any response arriving in the cycle after reset.
REQ-030 SHALL drive imem_request=0 during reset.

Structure
REQ-031 SHALL place the state enum, NOP_INSTR and PC_STEP (4) in the shared package fetch_pkg.
REQ-032 SHALL implement the hold buffer as the sub-module fetch_skid_buf (load, drain, flush, valid flag).

Verification
REQ-033 SHALL verify reset-and-stream: RESET_PC=0, stall=0, memory word k = 32'h1000_0000+k -> requests start the cycle after S_BOOT, and if_pc = 0,4,8,… with matching if_instr on consecutive cycles.
REQ-034 SHALL verify a stall with a response in flight: stall=1 for 3 cycles while the response for PC 0x8 arrives -> if_* frozen, imem_request=0, then on release PC 0x8 is output followed by 0xC with no gap or duplicate.
REQ-035 SHALL verify redirect-over-stall: stall=1 in S_HOLD plus redirect_pc=0x40 -> the buffer is flushed, if_valid=0, and PC 0x40 is output 3 cycles after the redirect.
REQ-036 SHALL verify misaligned redirect and wrap: redirect_pc=0x3FE -> imem_address=8'hFF and if_pc=0x3FC, then imem_address=8'h00 with if_pc=0x400.
REQ-037 SHALL verify reset mid-stream: rst=0 for 1 cycle during streaming -> if_valid=0, if_instr=NOP, and fetch restarts at RESET_PC with the stale response ignored.
